jk_bank_driver: RTL and testbench
=================================

JK_BANK_DRIVER -- requirements
Module: jk_bank_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the number of JK flip-flops driven.
REQ-002 SHALL have parameter RETRY_MAX, default 2, meaning the number of redrive attempts after the first drive fails.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  a target-state request is present.
REQ-006 SHALL have port req_ready  output  1  the driver can accept a request.
REQ-007 SHALL have port req_data  input  WIDTH  the target Q value for the bank.
REQ-008 SHALL have port q_fb  input  WIDTH  Q readback from the JK bank.
REQ-009 SHALL have port j  output  WIDTH  J drive to the bank, registered.
REQ-010 SHALL have port k  output  WIDTH  K drive to the bank, registered.
REQ-011 SHALL have port done  output  1  one-cycle pulse: the bank reached the target.
REQ-012 SHALL have port err  output  1  one-cycle pulse: the target was not reached after all retries.
REQ-013 SHALL have port err_mask  output  WIDTH  bits still mismatched at err; held until the next accept.

Function
REQ-014 SHALL implement the FSM states IDLE, DRIVE and CHECK.
REQ-015 SHALL drive req_ready = 1 only in IDLE and SHALL accept a request on a posedge where req_valid && req_ready.
REQ-016 SHALL latch req_data on acceptance, load j/k from the excitation of (q_fb, req_data) sampled at that edge, and enter DRIVE.
REQ-017 SHALL use this per-bit excitation: 0->0 gives J0 K0; 0->1 gives J1 K0; 1->0 gives J0 K1; 1->1 gives J0 K0; the toggle code J1 K1 SHALL never be issued.
REQ-018 SHALL hold j/k for exactly one cycle in DRIVE, then set j = k = 0 and enter CHECK.
REQ-019 SHALL, in CHECK on a match (q_fb == target), return to IDLE with done = 1 for the following cycle.
REQ-020 SHALL, in CHECK on a mismatch with retry count < RETRY_MAX, increment the count, reload j/k from the excitation of the current q_fb and target, and re-enter DRIVE.
REQ-021 SHALL, in CHECK on a mismatch with retry count == RETRY_MAX, return to IDLE, pulse err, and load err_mask = q_fb ^ target.
REQ-022 SHALL give nominal latency as: accept at edge A; DRIVE in cycle A+1; CHECK in cycle A+2; IDLE with done in cycle A+3; each retry adds 2 cycles.
REQ-023 SHALL clear the retry count on every accept.
REQ-024 SHALL still pass a request equal to the current q_fb through DRIVE with j = k = 0 and complete with done at A+3.
REQ-025 SHALL accept a back-to-back request in the same cycle as a done/err pulse, since req_ready = 1 there.
REQ-026 SHALL never assert done and err in the same cycle.
REQ-027 SHALL ignore req_valid and req_data outside IDLE.
REQ-028 SHALL treat WIDTH = 1 as a legal configuration.

Reset
REQ-029 SHALL, while rst = 1 at a posedge, go to IDLE with j = 0, k = 0, done = 0, err = 0, err_mask = 0, retry count = 0, and latched target = 0.
REQ-030 SHALL, on rst mid-operation (DRIVE or CHECK), abandon the request with no done/err pulse and set j = k = 0 at the same edge.
REQ-031 SHALL drive req_ready = 1 in the first cycle after rst deasserts.

Structure
REQ-032 SHALL place the state enum and the two-bit excitation codes (HOLD = 00, CLR = 01, SET = 10) in a shared package jk_drv_pkg.
REQ-033 SHALL use a combinational per-bit sub-module jk_excite (inputs q and target, outputs j and k), instantiated WIDTH times.
REQ-034 SHALL register all outputs except req_ready, which is decoded from state.

Verification
REQ-035 SHALL test: bench with 4 behavioural JK flip-flops on q_fb, all at 0; request 4'b1010 -> j = 1010, k = 0000 in cycle A+1, q_fb = 1010 in A+2, done in A+3.
REQ-036 SHALL test: from q_fb = 1010, request 4'b0110 -> j = 0100, k = 1000, done at A+3, and j & k == 0 in every cycle.
REQ-037 SHALL test: bit 0 of the bank stuck at 0, request 4'b0001 -> three DRIVE phases (j = 0001 each), then err at A+7 with err_mask = 0001 and no done.
REQ-038 SHALL test: bit 0 stuck for the first drive only -> one retry, done at A+5, err = 0.
REQ-039 SHALL test: rst asserted during CHECK -> next cycle in IDLE with j = k = 0, req_ready = 1, no done/err; a new request then completes normally.
REQ-040 SHALL test: req_valid held high across two requests -> second accepted in the done cycle; req_data changes while busy have no effect.

Source files
------------

// File: rtl/jk_drv_pkg.sv
// Shared types for the JK bank driver: controller states and the per-bit
// excitation codes, packed as {j, k}.
package jk_drv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2
   } state_e;

   // The toggle code {1,1} is deliberately absent.
   typedef enum logic [1:0] {
      HOLD = 2'b00,
      CLR  = 2'b01,
      SET  = 2'b10
   } exc_e;

endpackage

// File: rtl/jk_excite.sv
// Per-bit JK excitation: picks the J/K pair that moves q to target in one edge.
module jk_excite
   import jk_drv_pkg::*;
(
   input  logic q,
   input  logic target,
   output logic j,
   output logic k
);

   exc_e code;

   always_comb begin
      // NOTE: assign a default first so that every path drives code and no latch is inferred.
      code = HOLD;
      if (q != target) code = target ? SET : CLR;
   end

   assign j = code[1];
   assign k = code[0];

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a bank of JK flip-flops to a requested Q value, checks the readback
// and redrives up to RETRY_MAX times before reporting the stuck bits.
module jk_bank_driver
   import jk_drv_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int RETRY_MAX = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_data,
   input  logic [WIDTH-1:0] q_fb,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] err_mask
);

   localparam int CNT_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

   state_e           state;
   logic [WIDTH-1:0] target;
   logic [CNT_W-1:0] retry_cnt;
   logic [WIDTH-1:0] exc_target;
   logic [WIDTH-1:0] exc_j;
   logic [WIDTH-1:0] exc_k;

   assign req_ready = (state == IDLE);

   // On accept the excitation must see the incoming request, afterwards the latched one.
   assign exc_target = (state == IDLE) ? req_data : target;

   for (genvar i = 0; i < WIDTH; i++) begin : g_exc
      jk_excite u_exc (
         .q      (q_fb[i]),
         .target (exc_target[i]),
         .j      (exc_j[i]),
         .k      (exc_k[i])
      );
   end

   // NOTE: state registers use non-blocking assignments so every read in this block sees the pre-edge value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         target    <= '0;
         retry_cnt <= '0;
         j         <= '0;
         k         <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_mask  <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  target    <= req_data;
                  j         <= exc_j;
                  k         <= exc_k;
                  retry_cnt <= '0;
                  err_mask  <= '0;
                  state     <= DRIVE;
               end
            end
            DRIVE: begin
               j     <= '0;
               k     <= '0;
               state <= CHECK;
            end
            CHECK: begin
               if (q_fb == target) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end else if (retry_cnt < CNT_W'(RETRY_MAX)) begin
                  retry_cnt <= retry_cnt + 1'b1;
                  j         <= exc_j;
                  k         <= exc_k;
                  state     <= DRIVE;
               end else begin
                  err      <= 1'b1;
                  err_mask <= q_fb ^ target;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: a behavioural 4-bit JK bank with stuck-bit
// injection, a table of directed requests and hand-written corner sequences.
module tb_jk_bank_driver;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_data;
   logic [3:0] q_fb;
   logic [3:0] j;
   logic [3:0] k;
   logic       done;
   logic       err;
   logic [3:0] err_mask;

   logic [3:0] bank;
   logic [3:0] stuck;
   logic       bank_clr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   jk_bank_driver #(.WIDTH(4), .RETRY_MAX(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .q_fb      (q_fb),
      .j         (j),
      .k         (k),
      .done      (done),
      .err       (err),
      .err_mask  (err_mask)
   );

   // Behavioural JK bank; a stuck bit keeps its value regardless of J/K.
   always @(posedge clk) begin
      if (bank_clr) bank <= 4'b0000;
      else begin
         for (int i = 0; i < 4; i++) begin
            if (!stuck[i]) begin
               case ({j[i], k[i]})
                  2'b10:   bank[i] <= 1'b1;
                  2'b01:   bank[i] <= 1'b0;
                  2'b11:   bank[i] <= ~bank[i];
                  default: bank[i] <= bank[i];
               endcase
            end
         end
      end
   end
   assign q_fb = bank;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Invariants checked every cycle once out of reset.
   always @(negedge clk) begin
      if (!rst && !bank_clr) begin
         check("no_toggle_code", {28'd0, j & k}, 32'd0);
         check("done_err_exclusive", {31'd0, done & err}, 32'd0);
      end
   end

   typedef struct {
      logic [3:0] data;
      logic [3:0] exp_j;
      logic [3:0] exp_k;
      logic [3:0] stuck;
      bit         stuck_once;
      int         exp_lat;
      bit         exp_err;
      logic [3:0] exp_mask;
      int         exp_drives;
   } vec_t;

   vec_t vecs[9];

   task automatic run_req(input vec_t v);
      int  lat = 0;
      int  drives = 0;
      bit  seen_done = 0;
      bit  seen_err = 0;
      @(negedge clk);
      stuck     = v.stuck;
      req_valid = 1'b1;
      req_data  = v.data;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_data  = ~v.data;
      check("ready_busy", {31'd0, req_ready}, 32'd0);
      check("j_first", {28'd0, j}, {28'd0, v.exp_j});
      check("k_first", {28'd0, k}, {28'd0, v.exp_k});
      for (int c = 1; c <= 12; c++) begin
         if (c > 1) @(negedge clk);
         if (c == 2 && v.stuck_once) stuck = 4'b0000;
         if (j != 4'b0000 || k != 4'b0000) drives++;
         if (done || err) begin
            lat       = c;
            seen_done = done;
            seen_err  = err;
            break;
         end
      end
      check("pulse_seen", {31'd0, seen_done | seen_err}, 32'd1);
      check("latency", lat, v.exp_lat);
      check("done_pulse", {31'd0, seen_done}, {31'd0, !v.exp_err});
      check("err_pulse", {31'd0, seen_err}, {31'd0, v.exp_err});
      check("drive_phases", drives, v.exp_drives);
      check("err_mask", {28'd0, err_mask}, {28'd0, v.exp_mask});
      check("q_final", {28'd0, q_fb}, {28'd0, v.data ^ v.exp_mask});
      stuck = 4'b0000;
   endtask

   initial begin
      rst       = 1'b1;
      bank_clr  = 1'b1;
      stuck     = 4'b0000;
      req_valid = 1'b0;
      req_data  = 4'b0000;

      //          data     j        k        stuck    once lat err mask     drives
      vecs[0] = '{4'b1010, 4'b1010, 4'b0000, 4'b0000, 0,   3,  0,  4'b0000, 1};
      vecs[1] = '{4'b0110, 4'b0100, 4'b1000, 4'b0000, 0,   3,  0,  4'b0000, 1};
      vecs[2] = '{4'b0110, 4'b0000, 4'b0000, 4'b0000, 0,   3,  0,  4'b0000, 0};
      vecs[3] = '{4'b1001, 4'b1001, 4'b0110, 4'b0000, 0,   3,  0,  4'b0000, 1};
      vecs[4] = '{4'b0000, 4'b0000, 4'b1001, 4'b0000, 0,   3,  0,  4'b0000, 1};
      vecs[5] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 0,   7,  1,  4'b0001, 3};
      vecs[6] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 1,   5,  0,  4'b0000, 2};
      vecs[7] = '{4'b1111, 4'b1110, 4'b0000, 4'b0000, 0,   3,  0,  4'b0000, 1};
      vecs[8] = '{4'b0000, 4'b0000, 4'b1111, 4'b0000, 0,   3,  0,  4'b0000, 1};

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst      = 1'b0;
      bank_clr = 1'b0;
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_j", {28'd0, j}, 32'd0);
      check("rst_k", {28'd0, k}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_mask", {28'd0, err_mask}, 32'd0);

      foreach (vecs[i]) run_req(vecs[i]);

      // Reset while in CHECK: bank is 0000, request 1010.
      @(negedge clk);
      req_valid = 1'b1;
      req_data  = 4'b1010;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_j", {28'd0, j}, 32'd0);
      check("midrst_k", {28'd0, k}, 32'd0);
      check("midrst_ready", {31'd0, req_ready}, 32'd1);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_err", {31'd0, err}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("postrst_done", {31'd0, done}, 32'd0);
      check("postrst_err", {31'd0, err}, 32'd0);
      check("postrst_ready", {31'd0, req_ready}, 32'd1);
      run_req('{4'b0101, 4'b0101, 4'b1010, 4'b0000, 0, 3, 0, 4'b0000, 1});

      // req_valid held across two requests; data wiggles while busy.
      @(negedge clk);
      req_valid = 1'b1;
      req_data  = 4'b0011;
      @(posedge clk);
      @(negedge clk);
      check("b2b_j1", {28'd0, j}, {28'd0, 4'b0010});
      check("b2b_k1", {28'd0, k}, {28'd0, 4'b0100});
      req_data = 4'b1100;
      @(negedge clk);
      req_data = 4'b1111;
      @(negedge clk);
      check("b2b_done1", {31'd0, done}, 32'd1);
      check("b2b_ready_in_done", {31'd0, req_ready}, 32'd1);
      check("b2b_q1", {28'd0, q_fb}, {28'd0, 4'b0011});
      req_data = 4'b1000;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("b2b_accept2", {31'd0, req_ready}, 32'd0);
      check("b2b_j2", {28'd0, j}, {28'd0, 4'b1000});
      check("b2b_k2", {28'd0, k}, {28'd0, 4'b0011});
      @(negedge clk);
      check("b2b_no_early_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      check("b2b_done2", {31'd0, done}, 32'd1);
      check("b2b_q2", {28'd0, q_fb}, {28'd0, 4'b1000});

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
